// File: rtl/bus_dma_if.sv
// rtl/bus_dma_if.sv - slave register window and master bus signals of bus_dma
// master: the view of bus_dma itself; slave: the surrounding chip (CPU side and bus responders).
interface bus_dma_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        m_req_;
  logic        m_grnt_;
  logic [29:0] m_addr;
  logic        m_as_;
  logic        m_rw;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data;
  logic        m_rdy_;
  logic        irq;

  modport master (
    input  cs_, as_, rw, addr, wr_data, m_grnt_, m_rd_data, m_rdy_,
    output rd_data, rdy_, m_req_, m_addr, m_as_, m_rw, m_wr_data, irq
  );

  modport slave (
    output cs_, as_, rw, addr, wr_data, m_grnt_, m_rd_data, m_rdy_,
    input  rd_data, rdy_, m_req_, m_addr, m_as_, m_rw, m_wr_data, irq
  );
endinterface

// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - word-copy DMA engine: bus master m2 plus 4-register control window s5
// BUS_DMA_BURST_EN defined: bus request held for the whole transfer; undefined: re-requested per word.
module bus_dma #(
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      reset,
  bus_dma_if.master bus
);
  localparam logic DIR_RD = 1'b1;
  localparam logic DIR_WR = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [29:0]      src, dst;
  logic [CNT_W-1:0] count, count_dec;
  logic [31:0]      buffer;
  logic             done, irq_en, abort_pend;
  logic [31:0]      rd_data_q, reg_mux;
  logic             rdy_q;
  logic             acc, wr_acc, ctrl_wr, busy, start_cmd;

  assign acc       = ~bus.cs_ & ~bus.as_;
  assign wr_acc    = acc & (bus.rw == DIR_WR);
  assign ctrl_wr   = wr_acc & (bus.addr == 2'd3);
  assign busy      = (state != S_IDLE);
  assign start_cmd = ctrl_wr & bus.wr_data[0] & ~busy;
  assign count_dec = count - CNT_W'(1);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start_cmd) state_nx = (count != '0) ? S_REQ : S_DONE;
      S_REQ:     if (!bus.m_grnt_) state_nx = S_RD;
      S_RD:      state_nx = S_RD_WAIT;
      S_RD_WAIT: if (!bus.m_rdy_) state_nx = S_WR;
      S_WR:      state_nx = S_WR_WAIT;
      S_WR_WAIT: if (!bus.m_rdy_) state_nx = S_NEXT;
      S_NEXT: begin
        if (count_dec == '0 || abort_pend) state_nx = S_DONE;
`ifdef BUS_DMA_BURST_EN
        else state_nx = S_RD;
`else
        else state_nx = S_REQ;
`endif
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Bus outputs are a pure decode of the state so reset releases them immediately.
  always_comb begin
    bus.m_req_     = 1'b1;
    bus.m_as_      = 1'b1;
    bus.m_rw       = DIR_RD;
    bus.m_addr     = '0;
    bus.m_wr_data  = '0;
    case (state)
      S_REQ: bus.m_req_ = 1'b0;
      S_RD: begin
        bus.m_req_  = 1'b0;
        bus.m_as_   = 1'b0;
        bus.m_addr  = src;
      end
      S_RD_WAIT: begin
        bus.m_req_  = 1'b0;
        bus.m_addr  = src;
      end
      S_WR: begin
        bus.m_req_     = 1'b0;
        bus.m_as_      = 1'b0;
        bus.m_rw       = DIR_WR;
        bus.m_addr     = dst;
        bus.m_wr_data  = buffer;
      end
      S_WR_WAIT: begin
        bus.m_req_     = 1'b0;
        bus.m_rw       = DIR_WR;
        bus.m_addr     = dst;
        bus.m_wr_data  = buffer;
      end
`ifdef BUS_DMA_BURST_EN
      S_NEXT: bus.m_req_ = 1'b0;
`endif
      default: ;
    endcase
  end

  always_comb begin
    reg_mux = '0;
    case (bus.addr)
      2'd0: reg_mux = {2'b00, src};
      2'd1: reg_mux = {2'b00, dst};
      2'd2: reg_mux = 32'(count);
      2'd3: reg_mux = {27'd0, 1'b0, irq_en, done, busy, 1'b0};
      default: reg_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      src        <= '0;
      dst        <= '0;
      count      <= '0;
      buffer     <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      abort_pend <= 1'b0;
      rd_data_q  <= '0;
      rdy_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      rdy_q     <= ~acc;
      rd_data_q <= (acc && bus.rw == DIR_RD) ? reg_mux : '0;

      if (wr_acc && !busy) begin
        case (bus.addr)
          2'd0: src   <= bus.wr_data[29:0];
          2'd1: dst   <= bus.wr_data[29:0];
          2'd2: count <= bus.wr_data[CNT_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= bus.wr_data[3];
      if (ctrl_wr && busy && bus.wr_data[4]) abort_pend <= 1'b1;
      if (state == S_DONE) abort_pend <= 1'b0;

      // Entering DONE sets the flag and beats a same-cycle write-1-clear.
      if (state_nx == S_DONE && state != S_DONE) done <= 1'b1;
      else if (ctrl_wr && bus.wr_data[2])        done <= 1'b0;

      if (state == S_RD_WAIT && !bus.m_rdy_) buffer <= bus.m_rd_data;
      if (state == S_NEXT) begin
        src   <= src + 30'd1;
        dst   <= dst + 30'd1;
        count <= count_dec;
      end
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rdy_    = rdy_q;
  assign bus.irq     = done & irq_en;
endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - scoreboard bench for bus_dma with a zero-wait memory responder
module tb_bus_dma;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic gnt_block = 1'b0;
  always #5 clk = ~clk;

  bus_dma_if bif ();
  assign bif.m_grnt_ = bif.m_req_ | gnt_block;

  bus_dma #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bif));

  typedef struct {
    logic        wr;
    logic [29:0] a;
    logic [31:0] d;
  } acc_t;

  acc_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_rd = 0;
  int n_wr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [29:0] a);
    return {a[15:0] ^ 16'h5A5A, a[29:14]};
  endfunction

  // Memory responder and access monitor, both working on the falling edge.
  initial begin
    logic        resp_pend = 1'b0;
    logic        hold_chk = 1'b0;
    logic [29:0] hold_a = '0;
    logic        hold_rw = 1'b1;
    logic [31:0] hold_d = '0;
    acc_t        e;
    bif.m_rdy_ = 1'b1;
    bif.m_rd_data = '0;
    forever begin
      @(negedge clk);
      if (hold_chk && reset) begin
        check("hold_addr", {2'b00, bif.m_addr}, {2'b00, hold_a});
        check("hold_rw", {31'd0, bif.m_rw}, {31'd0, hold_rw});
        check("as_one_cycle", {31'd0, bif.m_as_}, 32'd1);
        if (!hold_rw) check("hold_wdata", bif.m_wr_data, hold_d);
      end
      hold_chk = 1'b0;
      bif.m_rdy_ = 1'b1;
      if (resp_pend) begin
        bif.m_rdy_ = 1'b0;
        bif.m_rd_data = mem_val(hold_a);
        resp_pend = 1'b0;
      end
      if (reset && bif.m_as_ == 1'b0) begin
        n_acc++;
        if (bif.m_rw) n_rd++;
        else n_wr++;
        if (exp_q.size() == 0) begin
          check("unexpected_access", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("acc_rw", {31'd0, bif.m_rw}, {31'd0, ~e.wr});
          check("acc_addr", {2'b00, bif.m_addr}, {2'b00, e.a});
          if (e.wr) check("acc_wdata", bif.m_wr_data, e.d);
        end
        hold_a = bif.m_addr;
        hold_rw = bif.m_rw;
        hold_d = bif.m_wr_data;
        hold_chk = 1'b1;
        resp_pend = 1'b1;
      end
    end
  end

  task automatic cpu_wr(input logic [1:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    bif.cs_ = 1'b0; bif.as_ = 1'b0; bif.rw = 1'b0; bif.addr = idx; bif.wr_data = d;
    @(posedge clk); #1;
    bif.cs_ = 1'b1; bif.as_ = 1'b1; bif.rw = 1'b1; bif.wr_data = '0;
    check("wr_rdy", {31'd0, bif.rdy_}, 32'd0);
  endtask

  task automatic cpu_rd(input logic [1:0] idx, output logic [31:0] d);
    @(posedge clk); #1;
    bif.cs_ = 1'b0; bif.as_ = 1'b0; bif.rw = 1'b1; bif.addr = idx;
    @(posedge clk); #1;
    bif.cs_ = 1'b1; bif.as_ = 1'b1;
    check("rd_rdy", {31'd0, bif.rdy_}, 32'd0);
    d = bif.rd_data;
  endtask

  task automatic reg_is(input string tag, input logic [1:0] idx, input logic [31:0] want);
    logic [31:0] v;
    cpu_rd(idx, v);
    check(tag, v, want);
  endtask

  task automatic run_copy(input logic [29:0] s, input logic [29:0] d, input int n,
                          input int n_exp, input logic [31:0] ctrl);
    logic [29:0] sa, da;
    cpu_wr(2'd0, {2'b00, s});
    cpu_wr(2'd1, {2'b00, d});
    cpu_wr(2'd2, n);
    for (int i = 0; i < n_exp; i++) begin
      sa = s + 30'(i);
      da = d + 30'(i);
      exp_q.push_back('{1'b0, sa, 32'd0});
      exp_q.push_back('{1'b1, da, mem_val(sa)});
    end
    cpu_wr(2'd3, ctrl);
    check("req_after_start", {31'd0, bif.m_req_}, 32'd0);
  endtask

  task automatic wait_acc(input logic wr, input int target);
    int i = 0;
    while ((wr ? n_wr : n_rd) < target && i < 300) begin
      @(negedge clk); #1;
      i++;
    end
    check("wait_acc", {31'd0, (wr ? n_wr : n_rd) >= target}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      @(negedge clk);
      i++;
    end
    check(tag, exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int base;
    bif.cs_ = 1'b1; bif.as_ = 1'b1; bif.rw = 1'b1; bif.addr = '0; bif.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", bif.rd_data, 32'd0);
    check("rst_rdy", {31'd0, bif.rdy_}, 32'd1);
    check("rst_req", {31'd0, bif.m_req_}, 32'd1);
    check("rst_as", {31'd0, bif.m_as_}, 32'd1);
    check("rst_rw", {31'd0, bif.m_rw}, 32'd1);
    check("rst_addr", {2'b00, bif.m_addr}, 32'd0);
    check("rst_wdata", bif.m_wr_data, 32'd0);
    check("rst_irq", {31'd0, bif.irq}, 32'd0);
    @(negedge clk) reset = 1'b1;
    for (int r = 0; r < 4; r++) reg_is("rst_reg", 2'(r), 32'd0);

    // Four-word copy; SRC write and START while busy must be ignored.
    run_copy(30'h100, 30'h200, 4, 4, 32'h1);
    wait_acc(1'b0, 1);
    cpu_wr(2'd0, 32'hABC);
    cpu_wr(2'd3, 32'h1);
    wait_drain("copy4_drain");
    reg_is("copy4_ctrl", 2'd3, 32'h4);
    reg_is("copy4_count", 2'd2, 32'd0);
    reg_is("copy4_src", 2'd0, 32'h104);
    reg_is("copy4_dst", 2'd1, 32'h204);
    cpu_wr(2'd3, 32'h4);
    reg_is("done_clr", 2'd3, 32'h0);

    // Interrupt timing: write access at k, NEXT at k+2, irq high at k+3.
    base = n_wr;
    run_copy(30'h300, 30'h310, 1, 1, 32'h9);
    wait_acc(1'b1, base + 1);
    @(negedge clk); check("irq_wr_wait", {31'd0, bif.irq}, 32'd0);
    @(negedge clk); check("irq_next", {31'd0, bif.irq}, 32'd0);
    @(negedge clk); check("irq_rise", {31'd0, bif.irq}, 32'd1);
    cpu_wr(2'd3, 32'h4);
    check("irq_clear", {31'd0, bif.irq}, 32'd0);
    wait_drain("irq_drain");

    // Grant withheld for 10 cycles.
    gnt_block = 1'b1;
    run_copy(30'h400, 30'h410, 2, 2, 32'h1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("nognt_req", {31'd0, bif.m_req_}, 32'd0);
      check("nognt_as", {31'd0, bif.m_as_}, 32'd1);
    end
    gnt_block = 1'b0;
    @(negedge clk);
    check("gnt_as", {31'd0, bif.m_as_}, 32'd0);
    check("gnt_addr", {2'b00, bif.m_addr}, 32'h400);
    wait_drain("gnt_drain");

    // Address wrap.
    run_copy(30'h3FFF_FFFF, 30'h500, 2, 2, 32'h1);
    wait_drain("wrap_drain");
    reg_is("wrap_src", 2'd0, 32'h1);
    cpu_wr(2'd3, 32'h4);

    // Abort during the second word of five.
    base = n_rd;
    run_copy(30'h600, 30'h700, 5, 2, 32'h1);
    wait_acc(1'b0, base + 2);
    cpu_wr(2'd3, 32'h10);
    wait_drain("abort_drain");
    repeat (20) @(negedge clk);
    reg_is("abort_ctrl", 2'd3, 32'h4);
    reg_is("abort_count", 2'd2, 32'd3);
    reg_is("abort_src", 2'd0, 32'h602);

    // Reset in WR_WAIT.
    base = n_wr;
    run_copy(30'h800, 30'h900, 4, 4, 32'h1);
    wait_acc(1'b1, base + 1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("rstmid_as", {31'd0, bif.m_as_}, 32'd1);
    check("rstmid_req", {31'd0, bif.m_req_}, 32'd1);
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    for (int r = 0; r < 4; r++) reg_is("rstmid_reg", 2'(r), 32'd0);

    // Zero count: DONE without bus traffic.
    base = n_acc;
    cpu_wr(2'd3, 32'h1);
    repeat (5) @(negedge clk);
    check("zero_no_access", n_acc, base);
    reg_is("zero_ctrl", 2'd3, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
